uart_baud_gen: RTL and testbench



---
 rtl/uart_baud_gen_if.sv | 25 ++
 rtl/uart_baud_gen.sv | 148 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: start/stop handshake and strobe outputs of the baud generator.
//   tx_start  master->slave  start request
//   tx_done   master->slave  stop request
//   busy      slave->master  high while the generator runs
//   os_tick   slave->master  one pulse per oversample period
//   bps_clk   slave->master  one pulse per bit (oversample index 0)
//   mid_tick  slave->master  one pulse at the bit centre
interface uart_baud_gen_if;
    logic tx_start;
    logic tx_done;
    logic busy;
    logic os_tick;
    logic bps_clk;
    logic mid_tick;

    modport master (
        output tx_start, tx_done,
        input  busy, os_tick, bps_clk, mid_tick
    );

    modport slave (
        input  tx_start, tx_done,
        output busy, os_tick, bps_clk, mid_tick
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud-rate strobe generator for the UART TX serialiser and RX sampler.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_baud_gen_if.slave (tx_start, tx_done in; busy, os_tick, bps_clk, mid_tick out)
// Parameters: CLK_FREQUENCE (Hz), BAUD_RATE (baud), OVERSAMPLE (1, 8 or 16).
// Build option: define BAUD_FRAC_EN to add the fractional error accumulator that
// stretches some periods by one clock so the long-term rate is exact.
module uart_baud_gen #(
    parameter int unsigned CLK_FREQUENCE = 50_000_000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter int unsigned OVERSAMPLE    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_baud_gen_if.slave  bus
);
    localparam int unsigned DEN     = BAUD_RATE * OVERSAMPLE;
    localparam int unsigned DIV_INT = CLK_FREQUENCE / DEN;
    localparam int unsigned CNT_WD  = $clog2(DIV_INT + 1);
    localparam int unsigned IDX_WD  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned MID_IDX = OVERSAMPLE / 2;
`ifdef BAUD_FRAC_EN
    localparam int unsigned REM     = CLK_FREQUENCE - DIV_INT * DEN;
    localparam int unsigned ERR_WD  = $clog2(DEN);
    localparam int unsigned SUM_WD  = ERR_WD + 1;
`endif

    // Reject configurations that cannot produce a meaningful period.
    generate
        if (DIV_INT < 2) begin : g_bad_div
            $error("uart_baud_gen: CLK_FREQUENCE/(BAUD_RATE*OVERSAMPLE) must be at least 2");
        end
        if (OVERSAMPLE != 1 && OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
            $error("uart_baud_gen: OVERSAMPLE must be 1, 8 or 16");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_WD-1:0]   r_count;
    logic [CNT_WD-1:0]   w_count_nxt;
    logic [IDX_WD-1:0]   r_os_idx;
    logic [IDX_WD-1:0]   w_os_idx_nxt;
    logic                r_os_tick;
    logic                w_os_tick_nxt;
    logic                r_bps_clk;
    logic                w_bps_clk_nxt;
    logic                r_mid_tick;
    logic                w_mid_tick_nxt;
    logic                w_last;
`ifdef BAUD_FRAC_EN
    logic [SUM_WD-1:0]   r_err;
    logic [SUM_WD-1:0]   w_err_nxt;
    logic [SUM_WD-1:0]   w_err_sum;
    logic                r_long;
    logic                w_long_nxt;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_os_idx   <= '0;
            r_os_tick  <= 1'b0;
            r_bps_clk  <= 1'b0;
            r_mid_tick <= 1'b0;
`ifdef BAUD_FRAC_EN
            r_err      <= '0;
            r_long     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_os_idx   <= w_os_idx_nxt;
            r_os_tick  <= w_os_tick_nxt;
            r_bps_clk  <= w_bps_clk_nxt;
            r_mid_tick <= w_mid_tick_nxt;
`ifdef BAUD_FRAC_EN
            r_err      <= w_err_nxt;
            r_long     <= w_long_nxt;
`endif
        end
    end

    // Next-state, period counter and strobe decode; everything clears in IDLE.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = '0;
        w_os_idx_nxt   = '0;
        w_os_tick_nxt  = 1'b0;
        w_bps_clk_nxt  = 1'b0;
        w_mid_tick_nxt = 1'b0;
        w_last         = 1'b0;
`ifdef BAUD_FRAC_EN
        w_err_nxt      = '0;
        w_long_nxt     = 1'b0;
        w_err_sum      = r_err + SUM_WD'(REM);
`endif
        case (r_state)
            IDLE: begin
                if (bus.tx_start) w_state_nxt = RUN;
            end
            RUN: begin
                if (bus.tx_done) w_state_nxt = IDLE;
                w_os_tick_nxt  = (r_count == CNT_WD'(1));
                w_bps_clk_nxt  = (r_count == CNT_WD'(1)) && (r_os_idx == '0);
                w_mid_tick_nxt = (r_count == CNT_WD'(1)) && (r_os_idx == IDX_WD'(MID_IDX));
`ifdef BAUD_FRAC_EN
                // Period length is decided at count 0 and held in r_long for the rest of it.
                w_err_nxt  = r_err;
                w_long_nxt = r_long;
                if (r_count == '0) begin
                    if (w_err_sum >= SUM_WD'(DEN)) begin
                        w_long_nxt = 1'b1;
                        w_err_nxt  = w_err_sum - SUM_WD'(DEN);
                    end else begin
                        w_long_nxt = 1'b0;
                        w_err_nxt  = w_err_sum;
                    end
                end
                w_last = (r_count == (w_long_nxt ? CNT_WD'(DIV_INT) : CNT_WD'(DIV_INT - 1)));
`else
                w_last = (r_count == CNT_WD'(DIV_INT - 1));
`endif
                if (w_last) begin
                    w_count_nxt  = '0;
                    w_os_idx_nxt = (r_os_idx == IDX_WD'(OVERSAMPLE - 1)) ? '0 : r_os_idx + IDX_WD'(1);
                end else begin
                    w_count_nxt  = r_count + CNT_WD'(1);
                    w_os_idx_nxt = r_os_idx;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.busy     = (r_state == RUN);
    assign bus.os_tick  = r_os_tick;
    assign bus.bps_clk  = r_bps_clk;
    assign bus.mid_tick = r_mid_tick;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed bench for uart_baud_gen with two instances
// (50 MHz / 9600 / OS=1 and 50 MHz / 115200 / OS=16). Follows BAUD_FRAC_EN.
module tb_uart_baud_gen;
    localparam int A_DIV = 5208;
    localparam int A_REM = 3200;
    localparam int A_DEN = 9600;
    localparam int B_DIV = 27;
    localparam int B_REM = 233600;
    localparam int B_DEN = 1843200;
`ifdef BAUD_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   q_os[$];
    int   q_bps[$];
    int   q_mid[$];

    always #5 clk = ~clk;

    uart_baud_gen_if if_a ();
    uart_baud_gen_if if_b ();

    uart_baud_gen #(.CLK_FREQUENCE(50_000_000), .BAUD_RATE(9600), .OVERSAMPLE(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    uart_baud_gen #(.CLK_FREQUENCE(50_000_000), .BAUD_RATE(115200), .OVERSAMPLE(16))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    typedef struct {
        string name;
        bit    start;
        bit    done;
        bit    exp_busy;
        bit    exp_tick;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit pulse_any(input bit sel);
        return sel ? (if_b.os_tick | if_b.bps_clk | if_b.mid_tick)
                   : (if_a.os_tick | if_a.bps_clk | if_a.mid_tick);
    endfunction

    // Pulse (or hold) tx_start across one edge and confirm busy rises.
    task automatic start_run(input bit sel, input bit hold, input string tag);
        @(negedge clk);
        if (sel) if_b.tx_start = 1'b1; else if_a.tx_start = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({tag, " busy after start"}, int'(sel ? if_b.busy : if_a.busy), 1);
        if (!hold) begin
            if (sel) if_b.tx_start = 1'b0; else if_a.tx_start = 1'b0;
        end
    endtask

    task automatic stop_run(input bit sel, input string tag);
        @(negedge clk);
        if (sel) if_b.tx_done = 1'b1; else if_a.tx_done = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({tag, " busy after done"}, int'(sel ? if_b.busy : if_a.busy), 0);
        if (sel) if_b.tx_done = 1'b0; else if_a.tx_done = 1'b0;
    endtask

    // Record cycle numbers (1 = after the first edge following start) of each pulse.
    task automatic capture(input bit sel, input int n);
        q_os.delete(); q_bps.delete(); q_mid.delete();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); @(negedge clk);
            if (sel ? if_b.os_tick  : if_a.os_tick)  q_os.push_back(c);
            if (sel ? if_b.bps_clk  : if_a.bps_clk)  q_bps.push_back(c);
            if (sel ? if_b.mid_tick : if_a.mid_tick) q_mid.push_back(c);
        end
    endtask

    // Build expected pulse times from the period recurrence and compare with capture.
    task automatic check_timing(input string tag, input int n, input int div,
                                input int rem, input int den, input int os);
        int e_os[$];
        int e_bps[$];
        int e_mid[$];
        int t;
        int err;
        int i;
        int p;
        t = 2; err = 0; i = 0;
        while (t <= n) begin
            e_os.push_back(t);
            if (i % os == 0)      e_bps.push_back(t);
            if (i % os == os / 2) e_mid.push_back(t);
            p = div;
            if (FRAC) begin
                err += rem;
                if (err >= den) begin
                    p = div + 1;
                    err -= den;
                end
            end
            t += p;
            i++;
        end
        chk($sformatf("%s os count", tag),  q_os.size(),  e_os.size());
        chk($sformatf("%s bps count", tag), q_bps.size(), e_bps.size());
        chk($sformatf("%s mid count", tag), q_mid.size(), e_mid.size());
        for (int k = 0; k < e_os.size() && k < q_os.size(); k++)
            chk($sformatf("%s os[%0d]", tag, k), q_os[k], e_os[k]);
        for (int k = 0; k < e_bps.size() && k < q_bps.size(); k++)
            chk($sformatf("%s bps[%0d]", tag, k), q_bps[k], e_bps[k]);
        for (int k = 0; k < e_mid.size() && k < q_mid.size(); k++)
            chk($sformatf("%s mid[%0d]", tag, k), q_mid[k], e_mid[k]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   npulse;

        vecs[0] = '{"done in idle ignored",  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"start+done in idle",    1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{"start in run ignored",  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"run first tick",        1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{"start+done in run",     1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"idle hold",             1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"start from idle",       1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{"done in run",           1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        if_a.tx_start = 1'b0; if_a.tx_done = 1'b0;
        if_b.tx_start = 1'b0; if_b.tx_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset a busy", int'(if_a.busy), 0);
        chk("reset a pulses", int'(pulse_any(1'b0)), 0);
        chk("reset b busy", int'(if_b.busy), 0);
        chk("reset b pulses", int'(pulse_any(1'b1)), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Handshake table on instance B: one edge per record.
        foreach (vecs[i]) begin
            if_b.tx_start = vecs[i].start;
            if_b.tx_done  = vecs[i].done;
            @(posedge clk); @(negedge clk);
            chk({vecs[i].name, " busy"}, int'(if_b.busy), int'(vecs[i].exp_busy));
            chk({vecs[i].name, " os_tick"}, int'(if_b.os_tick), int'(vecs[i].exp_tick));
            chk({vecs[i].name, " bps_clk"}, int'(if_b.bps_clk), int'(vecs[i].exp_tick));
            if_b.tx_start = 1'b0;
            if_b.tx_done  = 1'b0;
        end

        // B steady-state timing.
        start_run(1'b1, 1'b0, "b");
        capture(1'b1, 900);
        check_timing("b run", 900, B_DIV, B_REM, B_DEN, 16);
`ifndef BAUD_FRAC_EN
        if (q_bps.size() >= 2) chk("b bps spacing", q_bps[1] - q_bps[0], 432);
        if (q_mid.size() >= 1 && q_bps.size() >= 1) chk("b mid offset", q_mid[0] - q_bps[0], 216);
        if (q_os.size() >= 2) chk("b os spacing", q_os[1] - q_os[0], 27);
`endif
        stop_run(1'b1, "b");

        // tx_start held high through RUN must not disturb the period.
        start_run(1'b1, 1'b1, "b hold");
        capture(1'b1, 900);
        check_timing("b hold", 900, B_DIV, B_REM, B_DEN, 16);
        if_b.tx_start = 1'b0;
        stop_run(1'b1, "b hold");

        // Stop 100 clocks after start: no pulse after the cycle following the done edge.
        start_run(1'b1, 1'b0, "b stop");
        repeat (99) @(posedge clk);
        @(negedge clk);
        if_b.tx_done = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("b stop busy", int'(if_b.busy), 0);
        if_b.tx_done = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("b stop count", int'(dut_b.r_count), 0);
        chk("b stop os_idx", int'(dut_b.r_os_idx), 0);
`ifdef BAUD_FRAC_EN
        chk("b stop err", int'(dut_b.r_err), 0);
`endif
        npulse = int'(pulse_any(1'b1));
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (pulse_any(1'b1)) npulse++;
        end
        chk("b pulses after stop", npulse, 0);

        // Restart in the first IDLE cycle after done: same latency, state cleared.
        start_run(1'b1, 1'b0, "b pre");
        repeat (50) @(posedge clk);
        @(negedge clk);
        if_b.tx_done = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("b restart busy low", int'(if_b.busy), 0);
        if_b.tx_done  = 1'b0;
        if_b.tx_start = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("b restart busy high", int'(if_b.busy), 1);
        if_b.tx_start = 1'b0;
        capture(1'b1, 900);
        check_timing("b restart", 900, B_DIV, B_REM, B_DEN, 16);
        stop_run(1'b1, "b restart");

        // A: 9600 baud, one strobe per bit.
        start_run(1'b0, 1'b0, "a");
        capture(1'b0, 15700);
        check_timing("a run", 15700, A_DIV, A_REM, A_DEN, 1);
        if (q_bps.size() >= 4)
            chk("a three-bit span", q_bps[3] - q_bps[0], FRAC ? 15625 : 15624);
        stop_run(1'b0, "a");

        // Asynchronous reset mid-bit on A.
        start_run(1'b0, 1'b0, "a rst");
        repeat (3000) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a async rst busy", int'(if_a.busy), 0);
        chk("a async rst pulses", int'(pulse_any(1'b0)), 0);
        chk("a async rst count", int'(dut_a.r_count), 0);
        npulse = 0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (pulse_any(1'b0) || pulse_any(1'b1)) npulse++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); @(negedge clk);
            if (pulse_any(1'b0) || pulse_any(1'b1) || if_a.busy) npulse++;
        end
        chk("no pulses after reset", npulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
